// File: rtl/dual_axis_stepper_pkg.sv
// Shared constants and types for the dual-axis stepper: direction codes,
// axis FSM states, coil phase patterns and the angle range.
package dual_axis_stepper_pkg;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_DEC  = 2'b01;
    localparam logic [1:0] DIR_INC  = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2
    } axis_state_e;

    // Element [n] is the coil pattern for phase index n.
    localparam logic [3:0][3:0] COIL_LUT = {4'b1001, 4'b0011, 4'b0110, 4'b1100};

    localparam int unsigned DEG_MAX = 360;

    function automatic logic [3:0] coil_pattern(input logic [1:0] phase);
        return COIL_LUT[phase];
    endfunction

endpackage

// File: rtl/dual_axis_stepper_stepper_axis.sv
// One stepper axis: IDLE/MOVE/SETTLE FSM, phase index, micro-step counter and angle.
// HOLD_CURRENT_EN keeps the current phase pattern on the coils while not moving.
module stepper_axis
    import dual_axis_stepper_pkg::*;
#(
    parameter int unsigned STEPS_PER_DEG = 8,
    parameter int unsigned ANGLE_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               enable_i,
    input  logic [1:0]         code_i,
    input  logic               load_i,
    input  logic [ANGLE_W-1:0] load_val_i,
    output logic [3:0]         coils_o,
    output logic [ANGLE_W-1:0] angle_o,
    output logic               busy_o
);

    localparam int unsigned MICRO_W = (STEPS_PER_DEG > 1) ? $clog2(STEPS_PER_DEG) : 1;
    localparam logic [MICRO_W-1:0] MICRO_MAX = MICRO_W'(STEPS_PER_DEG - 1);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(DEG_MAX - 1);

    axis_state_e        state_q;
    logic [1:0]         dir_q;
    logic [1:0]         phase_q;
    logic [MICRO_W-1:0] micro_q;
    logic [ANGLE_W-1:0] angle_q;
    logic [3:0]         coils_q;
    logic               busy_q;

    logic [1:0]         code_eff_c;
    logic               move_code_c;
    logic [1:0]         step_phase_c;
    logic [MICRO_W-1:0] step_micro_c;
    logic [ANGLE_W-1:0] step_angle_c;
    logic [3:0]         idle_coils_c;

    // An invalid code behaves like stop for the FSM.
    assign code_eff_c   = (code_i == DIR_BAD) ? DIR_STOP : code_i;
    assign move_code_c  = (code_eff_c == DIR_INC) || (code_eff_c == DIR_DEC);
    assign step_phase_c = (dir_q == DIR_INC) ? phase_q + 2'd1 : phase_q - 2'd1;

`ifdef HOLD_CURRENT_EN
    assign idle_coils_c = coil_pattern(phase_q);
`else
    assign idle_coils_c = 4'b0000;
`endif

    // Micro-step and angle values if a step is taken in the latched direction.
    always_comb begin
        step_micro_c = micro_q;
        step_angle_c = angle_q;
        if (dir_q == DIR_INC) begin
            if (micro_q == MICRO_MAX) begin
                step_micro_c = '0;
                step_angle_c = (angle_q == ANGLE_MAX) ? '0 : angle_q + ANGLE_W'(1);
            end else begin
                step_micro_c = micro_q + MICRO_W'(1);
            end
        end else begin
            if (micro_q == '0) begin
                step_micro_c = MICRO_MAX;
                step_angle_c = (angle_q == '0) ? ANGLE_MAX : angle_q - ANGLE_W'(1);
            end else begin
                step_micro_c = micro_q - MICRO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_STOP;
            phase_q <= '0;
            micro_q <= '0;
            angle_q <= '0;
            coils_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            coils_q <= (state_q == ST_MOVE) ? coil_pattern(phase_q) : idle_coils_c;
            if (tick_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (enable_i && move_code_c) begin
                            state_q <= ST_MOVE;
                            dir_q   <= code_eff_c;
                            busy_q  <= 1'b1;
                            coils_q <= coil_pattern(phase_q);
                        end
                    end
                    ST_MOVE: begin
                        if (!enable_i || (code_eff_c == DIR_STOP)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            coils_q <= idle_coils_c;
                        end else if (code_eff_c == dir_q) begin
                            phase_q <= step_phase_c;
                            micro_q <= step_micro_c;
                            angle_q <= step_angle_c;
                            coils_q <= coil_pattern(step_phase_c);
                        end else begin
                            // Reversal: one dead tick before the new direction is accepted.
                            state_q <= ST_SETTLE;
                            busy_q  <= 1'b0;
                            coils_q <= idle_coils_c;
                        end
                    end
                    ST_SETTLE: state_q <= ST_IDLE;
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
            // A preset overrides any same-cycle angle/micro update; phase is kept.
            if (load_i) begin
                angle_q <= load_val_i;
                micro_q <= '0;
            end
        end
    end

    assign coils_o = coils_q;
    assign angle_o = angle_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/dual_axis_stepper.sv
// Two-axis stepper driver: shared step prescaler, preset validation and sticky fault.
// Optional HOLD_CURRENT_EN keeps coils energised on the current phase when idle.
module dual_axis_stepper
    import dual_axis_stepper_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 50000,
    parameter int unsigned STEPS_PER_DEG = 8,
    parameter int unsigned ANGLE_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         S_out_teta,
    input  logic [1:0]         S_out_fi,
    input  logic               load_en,
    input  logic [ANGLE_W-1:0] load_teta,
    input  logic [ANGLE_W-1:0] load_fi,
    output logic [3:0]         coils_teta,
    output logic [3:0]         coils_fi,
    output logic [ANGLE_W-1:0] teta_actual,
    output logic [ANGLE_W-1:0] fi_actual,
    output logic               busy_teta,
    output logic               busy_fi,
    output logic               fault
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [ANGLE_W-1:0] ANGLE_LIM = ANGLE_W'(DEG_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;
    logic             tick_c;
    logic             load_ok_c;
    logic             load_apply_c;
    logic             fault_set_c;

    assign tick_c       = (cnt_q == CNT_MAX);
    assign load_ok_c    = (load_teta < ANGLE_LIM) && (load_fi < ANGLE_LIM);
    assign load_apply_c = load_en && load_ok_c;
    assign fault_set_c  = (tick_c && ((S_out_teta == DIR_BAD) || (S_out_fi == DIR_BAD)))
                        || (load_en && !load_ok_c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
            if (fault_set_c) begin
                fault_q <= 1'b1;
            end
        end
    end

    stepper_axis #(
        .STEPS_PER_DEG(STEPS_PER_DEG),
        .ANGLE_W      (ANGLE_W)
    ) u_teta (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_c),
        .enable_i  (enable),
        .code_i    (S_out_teta),
        .load_i    (load_apply_c),
        .load_val_i(load_teta),
        .coils_o   (coils_teta),
        .angle_o   (teta_actual),
        .busy_o    (busy_teta)
    );

    stepper_axis #(
        .STEPS_PER_DEG(STEPS_PER_DEG),
        .ANGLE_W      (ANGLE_W)
    ) u_fi (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_c),
        .enable_i  (enable),
        .code_i    (S_out_fi),
        .load_i    (load_apply_c),
        .load_val_i(load_fi),
        .coils_o   (coils_fi),
        .angle_o   (fi_actual),
        .busy_o    (busy_fi)
    );

    assign fault = fault_q;

endmodule

// File: doc/dual_axis_stepper.md
# dual_axis_stepper

Drives the two stepper motors of the solar tracker (teta = vertical axis, fi = horizontal axis) from the 2-bit direction codes produced by the motion-control stage. Generates four-coil phase patterns at a fixed step rate and keeps the integer-degree position of each axis. These positions are fed back to the motion-control stage as `teta_actual` / `fi_actual`. Sits directly downstream of the direction comparator and directly upstream of the coil driver pins.

## Interface
Parameters:
- `CLK_DIV`, 50000: clocks per step tick, ≥2
- `STEPS_PER_DEG`, 8: full steps per degree, ≥1
- `ANGLE_W`, 16: width of angle ports

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `enable`  in  1  1 = stepping allowed; 0 = axes forced to IDLE on next tick
- `S_out_teta`  in  2  teta direction code: 00 stop, 01 decrement, 10 increment, 11 invalid
- `S_out_fi`  in  2  fi direction code, same encoding
- `load_en`  in  1  one-cycle strobe; presets both angles
- `load_teta`  in  ANGLE_W  preset value for teta
- `load_fi`  in  ANGLE_W  preset value for fi
- `coils_teta`  out  4  teta coil pattern
- `coils_fi`  out  4  fi coil pattern
- `teta_actual`  out  ANGLE_W  teta position, degrees, 0..359
- `fi_actual`  out  ANGLE_W  fi position, degrees, 0..359
- `busy_teta`  out  1  teta axis in MOVE
- `busy_fi`  out  1  fi axis in MOVE
- `fault`  out  1  sticky error flag

## Operation
- Prescaler counts 0..CLK_DIV-1. `tick` is a single-cycle pulse when the count equals CLK_DIV-1.
- Each axis runs an independent FSM with states IDLE, MOVE, SETTLE. Direction codes are sampled only on `tick`.
  - IDLE: on tick with `enable`=1 and code 01/10, latch the direction and go to MOVE.
  - MOVE: on each tick:
    - code equals the latched direction: take one step.
    - code 00, or `enable`=0: go to IDLE with no step.
    - code is the opposite direction: go to SETTLE with no step.
  - SETTLE: lasts exactly one tick, then returns to IDLE. This is the mandatory dead step before a reversal.
- Step behaviour:
  - Phase index 0..3 is +1 mod 4 for increment, −1 mod 4 for decrement.
  - Patterns: 0→1100, 1→0110, 2→0011, 3→1001.
  - Micro counter runs 0..STEPS_PER_DEG-1. Increment: wraps to 0 and adds 1 to the angle. Decrement: wraps from 0 to STEPS_PER_DEG-1 and subtracts 1 from the angle.
  - Angle wraps: 359+1→0, 0−1→359.
- Code 11 on a tick: treated as 00 for the FSM, and sets `fault`.
- Load behaviour:
  - `load_en` with both values <360: both angles take the preset values, micro counters clear, phase indices are unchanged.
  - If either value ≥360: load is discarded entirely and `fault` is set.
  - Load coinciding with a step: load wins, and that step's angle/micro update is dropped. The phase still advances.
- `fault` clears only on reset.
- `busy_*` = 1 in MOVE, 0 in IDLE and SETTLE.

## Timing
- Reset values:
  - `coils_*` = 0000
  - `teta_actual`, `fi_actual`, `busy_*`, `fault` = 0
  - Prescaler, phase indices and micro counters = 0
  - Both FSMs in IDLE
- A reset mid-move abandons the move immediately with no further step.
- All outputs are registered.
- On a stepping tick at cycle N, coil patterns, angles and busy reflect the new step at cycle N+1.
- From IDLE, the first step occurs on the tick after the transition to MOVE. Latency from code change to first coil change is therefore at most 2·CLK_DIV+1 cycles.
- Load takes effect at cycle N+1 after the strobe at N.
- Max step rate is one step per axis per CLK_DIV cycles. Both axes may step on the same tick.

## Configuration
- `HOLD_CURRENT_EN` defined: in IDLE/SETTLE, `coils_*` hold the pattern of the current phase index. After reset they show 1100 from cycle 1.
- `HOLD_CURRENT_EN` undefined: `coils_*` = 0000 whenever not in MOVE. In MOVE they show the current phase pattern.

## Structure
- Shared package holds:
  - Direction code constants: DIR_STOP=2'b00, DIR_DEC=2'b01, DIR_INC=2'b10, DIR_BAD=2'b11
  - Axis FSM state enum
  - Coil pattern lookup constant
  - DEG_MAX=360
- One sub-module `stepper_axis`: FSM, phase, micro counter and angle for one axis. It is instantiated twice, sharing the prescaler tick, load strobe and fault OR.

## Test plan
Bench configuration: CLK_DIV=4, STEPS_PER_DEG=2.
- Reset, code 10 held for 6 ticks → coils 0110,0011,1001,1100,0110,0011; `teta_actual` 0→1→2→3; busy=1 after first tick.
- Load teta=0, code 01 for 2 ticks → `teta_actual` = 359 after first step, stays 359 after second step; load fi=359, code 10 for 2 ticks → `fi_actual` = 0.
- MOVE with 10, then code switches to 01 → one tick SETTLE (no coil change, busy=0), one tick IDLE, then decrement steps.
- Code 11 on a tick → `fault`=1, axis to IDLE. Then load teta=360, fi=10 → both angles unchanged, `fault` stays 1 until `rst_n`=0.
- `load_en` on a stepping tick with load teta=100 → `teta_actual`=100 next cycle, coil phase still advanced; `enable`=0 → IDLE on next tick, coils 0000 without `HOLD_CURRENT_EN`, last pattern held with it.
- `rst_n`=0 mid-move → all outputs return to reset values the next cycle, no further coil change.
